// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch controller: funct3 codes, FSM states, defaults.
package branch_defs;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam int FLUSH_CYCLES_DEFAULT = 2;
  localparam int FLUSH_CNT_W          = 3;

endpackage

// File: rtl/branch_ctrl_if.sv
// Handshake and control bundle between EX/decode, the branch controller and the PC mux.
interface branch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            br_valid;
  logic            br_ready;
  logic            Branch;
  logic [2:0]      funct3;
  logic            alu_zero;
  logic            alu_lt;
  logic            alu_ltu;
  logic [XLEN-1:0] pc_ex;
  logic [XLEN-1:0] imm_b;
  logic            pc_src;
  logic [XLEN-1:0] pc_target;
  logic            flush;
  logic            stall;
  logic            br_illegal;

  modport master (
    output br_valid, Branch, funct3, alu_zero, alu_lt, alu_ltu, pc_ex, imm_b,
    input  br_ready, pc_src, pc_target, flush, stall, br_illegal
  );

  modport slave (
    input  br_valid, Branch, funct3, alu_zero, alu_lt, alu_ltu, pc_ex, imm_b,
    output br_ready, pc_src, pc_target, flush, stall, br_illegal
  );
endinterface

// File: rtl/branch_ctrl_encoder.sv
// Combinational branch encoder: funct3 condition evaluated against ALU flags.
module branch_ctrl_encoder
  import branch_defs::*;
(
  input  logic       Branch,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       Encoded_Branch,
  output logic       illegal
);

  logic cond;

  // Undefined funct3 codes (010, 011) are never taken and raise the illegal flag
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      BEQ:     cond = alu_zero;
      BNE:     cond = !alu_zero;
      BLT:     cond = alu_lt;
      BGE:     cond = !alu_lt;
      BLTU:    cond = alu_ltu;
      BGEU:    cond = !alu_ltu;
      default: illegal = Branch;
    endcase
    Encoded_Branch = Branch & cond;
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution sequencer: accept, one-cycle redirect, bounded flush window.
// Optional macro BRANCH_STATS_EN adds taken/not-taken outcome counters.
module branch_ctrl
  import branch_defs::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  branch_ctrl_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] taken_cnt,
  output logic [31:0] not_taken_cnt
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_t                 state_q, state_d;
  logic                   taken_q, illegal_q;
  logic [XLEN-1:0]        target_q;
  logic [FLUSH_CNT_W-1:0] cnt_q;
  logic                   enc_taken, enc_illegal;
  logic                   accept;

  branch_ctrl_encoder u_encoder (
    .Branch         (bus.Branch),
    .funct3         (bus.funct3),
    .alu_zero       (bus.alu_zero),
    .alu_lt         (bus.alu_lt),
    .alu_ltu        (bus.alu_ltu),
    .Encoded_Branch (enc_taken),
    .illegal        (enc_illegal)
  );

  // A candidate without the Branch flag is consumed without side effects
  assign accept = (state_q == IDLE) && bus.br_valid && bus.Branch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      target_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        taken_q   <= enc_taken;
        illegal_q <= enc_illegal;
        target_q  <= bus.pc_ex + bus.imm_b;
      end
      if (state_q == RESOLVE) begin
        cnt_q <= FLUSH_LOAD;
      end else if (state_q == FLUSH && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.br_ready   = 1'b0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.pc_src     = 1'b0;
    bus.br_illegal = 1'b0;
    case (state_q)
      IDLE: begin
        bus.br_ready = 1'b1;
        if (accept) state_d = RESOLVE;
      end
      RESOLVE: begin
        bus.stall      = 1'b1;
        bus.pc_src     = taken_q;
        bus.br_illegal = illegal_q;
        state_d        = taken_q ? FLUSH : IDLE;
      end
      FLUSH: begin
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pc_target = target_q;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else if (state_q == RESOLVE) begin
      if (taken_q) taken_cnt     <= taken_cnt + 32'd1;
      else         not_taken_cnt <= not_taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed vector table, corner sequences, random vs model.
module tb_branch_ctrl;
  import branch_defs::*;

  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_ctrl_if #(.XLEN(XLEN)) bus ();

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt, not_taken_cnt;
`endif

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
`endif
  );

  typedef struct {
    logic [2:0]  f3;
    logic        z, lt, ltu;
    logic [31:0] pc, imm;
    logic        taken, ill;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the funct3 truth table
  function automatic logic model_taken(input logic [2:0] f3, input logic z, lt, ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.br_valid = 1'b0;
    bus.Branch   = 1'b0;
    bus.funct3   = '0;
    bus.alu_zero = 1'b0;
    bus.alu_lt   = 1'b0;
    bus.alu_ltu  = 1'b0;
    bus.pc_ex    = '0;
    bus.imm_b    = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " br_ready"}, 32'(bus.br_ready), 32'd1);
    check({tag, " stall"},    32'(bus.stall),    32'd0);
    check({tag, " flush"},    32'(bus.flush),    32'd0);
    check({tag, " pc_src"},   32'(bus.pc_src),   32'd0);
  endtask

  // Drives a one-cycle branch from IDLE and follows it back to IDLE
  task automatic applyStimulus(input string tag, input vec_t v);
    check({tag, " ready_pre"}, 32'(bus.br_ready), 32'd1);
    bus.br_valid = 1'b1;
    bus.Branch   = 1'b1;
    bus.funct3   = v.f3;
    bus.alu_zero = v.z;
    bus.alu_lt   = v.lt;
    bus.alu_ltu  = v.ltu;
    bus.pc_ex    = v.pc;
    bus.imm_b    = v.imm;
    tick();
    idle_inputs();
    check({tag, " pc_src"},     32'(bus.pc_src),     32'(v.taken));
    check({tag, " br_illegal"}, 32'(bus.br_illegal), 32'(v.ill));
    check({tag, " res_stall"},  32'(bus.stall),      32'd1);
    check({tag, " res_ready"},  32'(bus.br_ready),   32'd0);
    check({tag, " res_flush"},  32'(bus.flush),      32'd0);
    if (v.taken) begin
      check({tag, " pc_target"}, bus.pc_target, v.tgt);
      for (int i = 0; i < FC; i++) begin
        tick();
        check($sformatf("%s flush%0d", tag, i), 32'(bus.flush), 32'd1);
        check($sformatf("%s fstall%0d", tag, i), 32'(bus.stall), 32'd1);
        check($sformatf("%s fready%0d", tag, i), 32'(bus.br_ready), 32'd0);
      end
    end
    tick();
    check_idle({tag, " post"});
    check({tag, " post_illegal"}, 32'(bus.br_illegal), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vec_t rv;
    idle_inputs();
    do_reset();

    // Reset state
    check_idle("reset");
    check("reset br_illegal", 32'(bus.br_illegal), 32'd0);
    check("reset pc_target", bus.pc_target, 32'd0);

    vecs[0] = '{BEQ,    1, 0, 0, 32'h100,      32'h20,       1, 0, 32'h120};
    vecs[1] = '{BNE,    1, 0, 0, 32'h200,      32'h40,       0, 0, 32'h240};
    vecs[2] = '{BLT,    0, 0, 1, 32'h300,      32'h10,       0, 0, 32'h310};
    vecs[3] = '{BLTU,   0, 0, 1, 32'h300,      32'h10,       1, 0, 32'h310};
    vecs[4] = '{BGE,    0, 0, 1, 32'h400,      32'h8,        1, 0, 32'h408};
    vecs[5] = '{BGEU,   0, 0, 1, 32'h400,      32'h8,        0, 0, 32'h408};
    vecs[6] = '{3'b010, 1, 1, 1, 32'h500,      32'h4,        0, 1, 32'h504};
    vecs[7] = '{BEQ,    1, 0, 0, 32'hFFFFFFF0, 32'h20,       1, 0, 32'h10};
    vecs[8] = '{3'b011, 1, 0, 0, 32'h600,      32'h4,        0, 1, 32'h604};
    vecs[9] = '{BNE,    0, 1, 0, 32'h2000,     32'hFFFFFFF8, 1, 0, 32'h1FF8};

    for (int i = 0; i < 10; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // Non-branch candidate is a no-op
    bus.br_valid = 1'b1;
    bus.Branch   = 1'b0;
    bus.funct3   = BEQ;
    bus.alu_zero = 1'b1;
    tick();
    idle_inputs();
    check_idle("nop");

    // Held valid: not re-accepted until IDLE, then accepted in the first IDLE cycle
    bus.br_valid = 1'b1;
    bus.Branch   = 1'b1;
    bus.funct3   = BNE;
    bus.alu_zero = 1'b1;
    tick();
    check("held res1 stall", 32'(bus.stall), 32'd1);
    tick();
    check("held idle stall", 32'(bus.stall), 32'd0);
    check("held idle ready", 32'(bus.br_ready), 32'd1);
    tick();
    check("held res2 stall", 32'(bus.stall), 32'd1);
    idle_inputs();
    tick();
    check_idle("held end");

    // Reset in first FLUSH cycle with valid held across reset
    bus.br_valid = 1'b1;
    bus.Branch   = 1'b1;
    bus.funct3   = BEQ;
    bus.alu_zero = 1'b1;
    bus.pc_ex    = 32'h700;
    bus.imm_b    = 32'h100;
    tick();
    check("rst_mid resolve pc_src", 32'(bus.pc_src), 32'd1);
    tick();
    check("rst_mid flush", 32'(bus.flush), 32'd1);
    reset = 1'b1;
    tick();
    check_idle("rst_mid after");
    check("rst_mid target clr", bus.pc_target, 32'd0);
    tick();
    check_idle("rst_mid held");
    reset = 1'b0;
    tick();
    check("rst_mid accept stall", 32'(bus.stall), 32'd1);
    check("rst_mid accept pc_src", 32'(bus.pc_src), 32'd1);
    check("rst_mid accept target", bus.pc_target, 32'h800);
    idle_inputs();
    for (int i = 0; i < FC; i++) tick();
    tick();
    check_idle("rst_mid drained");

    // Randomised branches against the model
    for (int i = 0; i < 40; i++) begin
      rv.f3    = 3'($urandom_range(0, 7));
      rv.z     = 1'($urandom);
      rv.lt    = 1'($urandom);
      rv.ltu   = 1'($urandom);
      rv.pc    = $urandom;
      rv.imm   = $urandom;
      rv.taken = model_taken(rv.f3, rv.z, rv.lt, rv.ltu);
      rv.ill   = (rv.f3 == 3'd2) || (rv.f3 == 3'd3);
      rv.tgt   = rv.pc + rv.imm;
      applyStimulus($sformatf("rnd%0d", i), rv);
    end

`ifdef BRANCH_STATS_EN
    do_reset();
    check("stats reset taken", taken_cnt, 32'd0);
    check("stats reset not_taken", not_taken_cnt, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus("st_t", vecs[0]);
    for (int i = 0; i < 2; i++) applyStimulus("st_n", vecs[1]);
    applyStimulus("st_i", vecs[6]);
    check("stats taken", taken_cnt, 32'd3);
    check("stats not_taken", not_taken_cnt, 32'd3);
    do_reset();
    check("stats clr taken", taken_cnt, 32'd0);
    check("stats clr not_taken", not_taken_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
